// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with memory wait-state FSM and timeout; perf counters under HAZARD_PERF_EN
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Ra1D,
    input  logic [3:0]  Ra2D,
    input  logic [3:0]  Ra1E,
    input  logic [3:0]  Ra2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        PCSrcD,
    input  logic        PCSrcE,
    input  logic        PCSrcM,
    input  logic        PCSrcW,
    input  logic        BranchTakenE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ldr_stall, pc_pend, mem_stall, mem_err;

    function automatic logic [1:0] fwd(input logic [3:0] ra, input logic wm, input logic [3:0] am,
                                       input logic ww, input logic [3:0] aw);
        return (ra == 4'hF) ? 2'b00 : (wm && am == ra) ? 2'b10 : (ww && aw == ra) ? 2'b01 : 2'b00;
    endfunction

    assign ldr_stall = MemtoRegE && RegWriteE && (Ra1D == WA3E || Ra2D == WA3E);
    assign pc_pend   = PCSrcD || PCSrcE || PCSrcM;
    assign mem_stall = (state == IDLE && MemReqM && !MemReadyM) || (state == WAIT && !MemReadyM) || state == ERR;

    assign ForwardAE = reset ? 2'b00 : fwd(Ra1E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign ForwardBE = reset ? 2'b00 : fwd(Ra2E, RegWriteM, WA3M, RegWriteW, WA3W);

    // memory stall freezes the pipe and defers branch/PC flushes to the release cycle
    assign StallF = !reset && (mem_stall || ldr_stall || pc_pend);
    assign StallD = !reset && (mem_stall || ldr_stall);
    assign StallE = !reset && mem_stall;
    assign StallM = !reset && mem_stall;
    assign FlushD = !reset && !mem_stall && (pc_pend || PCSrcW || BranchTakenE);
    assign FlushE = !reset && !mem_stall && (ldr_stall || BranchTakenE);
    assign FlushW = !reset && mem_stall;
    assign MemErr = mem_err;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE && MemReqM && !MemReadyM) begin
            state_n = WAIT;
            cnt_n   = CW'(1);
        end else if (state == WAIT) begin
            state_n = MemReadyM ? IDLE : (cnt == CW'(MEM_TIMEOUT)) ? ERR : WAIT;
            cnt_n   = MemReadyM ? '0 : (cnt == CW'(MEM_TIMEOUT)) ? cnt : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mem_err <= mem_err || state_n == ERR;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != ERR) begin
            stall_cnt <= stall_cnt + 32'(StallF);
            flush_cnt <= flush_cnt + 32'(FlushD || FlushE || FlushW);
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage ARM core. It drives the stall and flush inputs of the fetch, decode, execute, memory and writeback pipeline registers. It generates the operand-forwarding selects for the execute stage. It also runs a wait-state handshake with the data memory, including a timeout watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, 255: number of memory wait cycles tolerated before the fatal error state (≥1). The counter width is $clog2(MEM_TIMEOUT+1).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Ra1D, Ra2D  in  4  source registers of the instruction in decode.
- Ra1E, Ra2E  in  4  source registers of the instruction in execute.
- WA3E, WA3M, WA3W  in  4  destination register in execute, memory and writeback.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- MemtoRegE  in  1  the instruction in execute is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  the instruction in that stage writes the PC.
- BranchTakenE  in  1  a branch in execute resolved taken.
- MemReqM  in  1  the memory stage is accessing data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  execute operand select: 00 register file, 01 writeback result, 10 memory ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (insert a bubble).
- MemErr  out  1  sticky memory-timeout error flag.
- StallCnt, FlushCnt  out  32  performance counters (see Configuration).

## Operation
Combinational terms:
- ForwardAE = 10 if RegWriteM and WA3M==Ra1E. Otherwise 01 if RegWriteW and WA3W==Ra1E. Otherwise 00.
- ForwardBE follows the same rule using Ra2E.
- Register 4'hF never forwards.
- ldrStall = MemtoRegE & RegWriteE & (Ra1D==WA3E | Ra2D==WA3E).
- pcPend = PCSrcD | PCSrcE | PCSrcM.
- memStall = (state==IDLE & MemReqM & ~MemReadyM) | (state==WAIT & ~MemReadyM) | state==ERR.

Outputs when memStall=1:
- StallF/D/E/M=1, FlushW=1, FlushD=0, FlushE=0.
- Branch and PC flushes are deferred; the requesting instruction is held in place, so they fire on the release cycle.

Outputs when memStall=0:
- StallF = ldrStall | pcPend.
- StallD = ldrStall.
- StallE = StallM = 0.
- FlushD = pcPend | PCSrcW | BranchTakenE.
- FlushE = ldrStall | BranchTakenE.
- FlushW = 0.

Memory FSM (states IDLE, WAIT, ERR) with wait counter cnt:
- IDLE, MemReqM & ~MemReadyM: go to WAIT, cnt←1.
- IDLE, otherwise: stay in IDLE.
- WAIT, MemReadyM: go to IDLE, cnt←0. Stalls drop in this same cycle.
- WAIT, ~MemReadyM, cnt==MEM_TIMEOUT: go to ERR.
- WAIT, ~MemReadyM, cnt<MEM_TIMEOUT: cnt←cnt+1.
- ERR: absorbing state. MemErr=1 and the pipeline stays frozen until reset.
- MemReadyM is ignored when MemReqM=0 in IDLE.

## Timing
- Reset values: state=IDLE, cnt=0, MemErr=0, StallCnt=FlushCnt=0.
- While reset is high, all Stall*/Flush* outputs are forced to 0 and ForwardAE=ForwardBE=00.
- Forward, stall and flush outputs are combinational, with zero latency from their inputs.
- MemErr is registered; it rises the cycle after the ERR transition.
- A zero-wait access (MemReqM and MemReadyM in the same cycle) produces no stall.
- An access with N wait cycles, N ≤ MEM_TIMEOUT, stalls for exactly N cycles.
- If ready never arrives, there are MEM_TIMEOUT+1 stalled cycles and then ERR.
- Simultaneous ldrStall and BranchTakenE: FlushE=1, StallD=1, FlushD=1. The flush wins on the decode register.
- Reset asserted mid-WAIT returns to IDLE asynchronously.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCnt increments on every cycle with StallF=1.
  - FlushCnt increments on every cycle with FlushD|FlushE|FlushW=1.
  - Both are 32-bit, wrap modulo 2^32, reset to 0, and are frozen in ERR.
- HAZARD_PERF_EN undefined: the counters are not built, and StallCnt and FlushCnt are tied to 0.

## Test plan
- Forwarding:
  - RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, Ra1E=3 → ForwardAE=10. Clear RegWriteM → ForwardAE=01.
  - WA3M=15, Ra1E=15 → ForwardAE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, Ra2D=5 → StallF=1, StallD=1, FlushE=1 for one cycle. Then WA3E=6 → all 0.
- Branch: BranchTakenE=1 → FlushD=1, FlushE=1, StallF=0. PCSrcE=1 → StallF=1, FlushD=1.
- Memory wait, MEM_TIMEOUT=4: MemReqM=1, MemReadyM low for 3 cycles then high → StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, then IDLE and MemErr=0.
- Timeout, MEM_TIMEOUT=4: MemReqM held, MemReadyM never asserted → 5 stalled cycles, MemErr=1 from the 6th cycle onward, stalls stay high. Asserting reset → MemErr=0 and outputs cleared immediately.
- With HAZARD_PERF_EN: 3 load-use stalls plus 2 taken branches → StallCnt=3, FlushCnt=5.
